// File: rtl/rotate_square_anim.sv
// Rotating-square animation for an N-digit 7-segment display.
// A square glyph walks the top row left to right, then the bottom row back.
module rotate_square_anim #(
  parameter int N_DIGITS = 4,
  parameter int TICK_DIV = 25_000_000,
  parameter bit ACTIVE_LOW = 1'b0,
  localparam int POS_W =
    ($clog2(2*N_DIGITS) > 1) ? $clog2(2*N_DIGITS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                cw,
  input  logic                blank,
  output logic [6:0]          seg,
  output logic [N_DIGITS-1:0] an,
  output logic [POS_W-1:0]    pos,
  output logic                step
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int N_POS = 2 * N_DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_POS - 1);
  localparam logic [POS_W-1:0] POS_N    = POS_W'(N_DIGITS);
  localparam logic [POS_W:0]   POS_END  = (POS_W+1)'(N_POS);

  localparam logic [6:0] GLYPH_TOP = 7'b1100011;
  localparam logic [6:0] GLYPH_BOT = 7'b0011101;

  logic [CNT_W-1:0]    cnt;
  logic                tick;
  logic                valid;
  logic                top;
  logic [POS_W-1:0]    pos_next;
  logic [6:0]          seg_raw;
  logic [N_DIGITS-1:0] an_raw;

  assign tick  = en && (cnt == CNT_LAST);
  assign valid = ({1'b0, pos} < POS_END);
  assign top   = (pos < POS_N);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Out-of-range positions recover to 0 on the next step.
  always_comb begin
    pos_next = '0;
    if (!valid) begin
      pos_next = '0;
    end else if (cw) begin
      pos_next = (pos == POS_LAST) ? '0 : pos + POS_W'(1);
    end else begin
      pos_next = (pos == '0) ? POS_LAST : pos - POS_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos  <= '0;
      step <= 1'b0;
    end else begin
      step <= tick;
      if (tick) begin
        pos <= pos_next;
      end
    end
  end

  // Digit 0 is the leftmost digit and maps to the MSB of an.
  always_comb begin
    seg_raw = '0;
    an_raw  = '0;
    if (!blank && valid) begin
      seg_raw = top ? GLYPH_TOP : GLYPH_BOT;
      for (int i = 0; i < N_DIGITS; i++) begin
        if (top) begin
          an_raw[i] = (i == N_DIGITS - 1 - int'(pos));
        end else begin
          an_raw[i] = (i == int'(pos) - N_DIGITS);
        end
      end
    end
  end

  assign seg = ACTIVE_LOW ? ~seg_raw : seg_raw;
  assign an  = ACTIVE_LOW ? ~an_raw  : an_raw;

endmodule

// File: tb/tb_rotate_square_anim.sv
// Directed bench for rotate_square_anim: three instances
// (N=4/TD=4 active-high, N=4/TD=4 active-low, N=1/TD=1).
module tb_rotate_square_anim;

  logic clk = 1'b0;
  logic reset, en, cw, blank;

  logic [6:0] seg_a, seg_b, seg_c;
  logic [3:0] an_a, an_b;
  logic       an_c;
  logic [2:0] pos_a, pos_b;
  logic       pos_c;
  logic       step_a, step_b, step_c;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [6:0] TOP = 7'b1100011;
  localparam logic [6:0] BOT = 7'b0011101;

  logic [6:0] seg_tab [8] = '{TOP, TOP, TOP, TOP, BOT, BOT, BOT, BOT};
  logic [3:0] an_tab  [8] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001,
                              4'b0001, 4'b0010, 4'b0100, 4'b1000};

  rotate_square_anim #(.N_DIGITS(4), .TICK_DIV(4), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .reset(reset), .en(en), .cw(cw), .blank(blank),
    .seg(seg_a), .an(an_a), .pos(pos_a), .step(step_a)
  );

  rotate_square_anim #(.N_DIGITS(4), .TICK_DIV(4), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .reset(reset), .en(en), .cw(cw), .blank(blank),
    .seg(seg_b), .an(an_b), .pos(pos_b), .step(step_b)
  );

  rotate_square_anim #(.N_DIGITS(1), .TICK_DIV(1), .ACTIVE_LOW(1'b0)) dut_c (
    .clk(clk), .reset(reset), .en(en), .cw(cw), .blank(blank),
    .seg(seg_c), .an(an_c), .pos(pos_c), .step(step_c)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; cw = 1'b1; blank = 1'b0;
    #2;
    n_checks++;
    if (pos_a !== 3'd0 || step_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pos_step: pos=%0d step=%b required pos=0 step=0", pos_a, step_a);
    end
    n_checks++;
    if (seg_a !== TOP || an_a !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_decode: seg=%b an=%b required seg=%b an=1000", seg_a, an_a, TOP);
    end
    n_checks++;
    if (seg_b !== 7'b0011100 || an_b !== 4'b0111) begin
      n_fail++;
      $display("FAIL reset_active_low: seg=%b an=%b required seg=0011100 an=0111", seg_b, an_b);
    end
    n_checks++;
    if (pos_c !== 1'b0 || step_c !== 1'b0 || an_c !== 1'b1 || seg_c !== TOP) begin
      n_fail++;
      $display("FAIL reset_n1: pos=%b step=%b an=%b seg=%b required 0 0 1 %b",
               pos_c, step_c, an_c, seg_c, TOP);
    end
    cyc();
    cyc();
  endtask

  task automatic test_cw_loop();
    reset = 1'b0; en = 1'b1; cw = 1'b1;
    for (int s = 1; s <= 8; s++) begin
      for (int k = 0; k < 3; k++) begin
        cyc();
        n_checks++;
        if (step_a !== 1'b0) begin
          n_fail++;
          $display("FAIL cw_nostep: step %0d cycle %0d step=%b required 0", s, k, step_a);
        end
      end
      cyc();
      n_checks++;
      if (step_a !== 1'b1 || pos_a !== 3'(s % 8)) begin
        n_fail++;
        $display("FAIL cw_step: step=%b pos=%0d required step=1 pos=%0d", step_a, pos_a, s % 8);
      end
      n_checks++;
      if (seg_a !== seg_tab[s % 8] || an_a !== an_tab[s % 8]) begin
        n_fail++;
        $display("FAIL cw_decode: p=%0d seg=%b an=%b required seg=%b an=%b",
                 s % 8, seg_a, an_a, seg_tab[s % 8], an_tab[s % 8]);
      end
    end
  endtask

  task automatic test_ccw_wrap();
    cw = 1'b0;
    repeat (4) cyc();
    n_checks++;
    if (pos_a !== 3'd7 || an_a !== 4'b1000 || seg_a !== BOT || step_a !== 1'b1) begin
      n_fail++;
      $display("FAIL ccw_wrap: pos=%0d an=%b seg=%b step=%b required 7 1000 %b 1",
               pos_a, an_a, seg_a, step_a, BOT);
    end
    repeat (4) cyc();
    n_checks++;
    if (pos_a !== 3'd6 || an_a !== 4'b0100) begin
      n_fail++;
      $display("FAIL ccw_next: pos=%0d an=%b required pos=6 an=0100", pos_a, an_a);
    end
  endtask

  task automatic test_enable_dir();
    repeat (2) cyc();
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      n_checks++;
      if (pos_a !== 3'd6 || step_a !== 1'b0) begin
        n_fail++;
        $display("FAIL en_freeze: cycle %0d pos=%0d step=%b required pos=6 step=0", k, pos_a, step_a);
      end
    end
    en = 1'b1;
    repeat (3) cyc();
    n_checks++;
    if (pos_a !== 3'd6 || step_a !== 1'b0) begin
      n_fail++;
      $display("FAIL en_restart_early: pos=%0d step=%b required pos=6 step=0", pos_a, step_a);
    end
    cyc();
    n_checks++;
    if (pos_a !== 3'd5 || step_a !== 1'b1) begin
      n_fail++;
      $display("FAIL en_restart_step: pos=%0d step=%b required pos=5 step=1", pos_a, step_a);
    end
    cyc(); cw = 1'b1;
    cyc(); cw = 1'b0;
    n_checks++;
    if (pos_a !== 3'd5) begin
      n_fail++;
      $display("FAIL dir_between_ticks: pos=%0d required 5", pos_a);
    end
    cyc(); cw = 1'b1;
    cyc();
    n_checks++;
    if (pos_a !== 3'd6 || step_a !== 1'b1) begin
      n_fail++;
      $display("FAIL dir_reversal: pos=%0d step=%b required pos=6 step=1", pos_a, step_a);
    end
  endtask

  task automatic test_blank();
    blank = 1'b1;
    #1;
    n_checks++;
    if (seg_a !== 7'b0000000 || an_a !== 4'b0000) begin
      n_fail++;
      $display("FAIL blank_high: seg=%b an=%b required 0000000 0000", seg_a, an_a);
    end
    n_checks++;
    if (seg_b !== 7'b1111111 || an_b !== 4'b1111) begin
      n_fail++;
      $display("FAIL blank_low: seg=%b an=%b required 1111111 1111", seg_b, an_b);
    end
    @(posedge clk); #1;
    repeat (3) cyc();
    n_checks++;
    if (pos_a !== 3'd7 || step_a !== 1'b1 || seg_a !== 7'b0000000) begin
      n_fail++;
      $display("FAIL blank_runs: pos=%0d step=%b seg=%b required 7 1 0000000", pos_a, step_a, seg_a);
    end
    blank = 1'b0;
    #1;
    n_checks++;
    if (seg_a !== BOT || an_a !== 4'b1000) begin
      n_fail++;
      $display("FAIL unblank: seg=%b an=%b required %b 1000", seg_a, an_a, BOT);
    end
    n_checks++;
    if (seg_b !== 7'b1100010 || an_b !== 4'b0111) begin
      n_fail++;
      $display("FAIL unblank_low: seg=%b an=%b required 1100010 0111", seg_b, an_b);
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    #1;
    n_checks++;
    if (pos_a !== 3'd0 || step_a !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: pos=%0d step=%b required 0 0", pos_a, step_a);
    end
    cyc();
    reset = 1'b0; en = 1'b1; cw = 1'b1;
    repeat (20) cyc();
    n_checks++;
    if (pos_a !== 3'd5) begin
      n_fail++;
      $display("FAIL reach_p5: pos=%0d required 5", pos_a);
    end
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
    n_checks++;
    if (pos_a !== 3'd0 || step_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_on_tick: pos=%0d step=%b required 0 0", pos_a, step_a);
    end
  endtask

  task automatic test_tick_div1();
    logic exp_pos;
    reset = 1'b0; en = 1'b1; cw = 1'b1;
    exp_pos = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      exp_pos = ~exp_pos;
      n_checks++;
      if (pos_c !== exp_pos || step_c !== 1'b1 || an_c !== 1'b1 ||
          seg_c !== (exp_pos ? BOT : TOP)) begin
        n_fail++;
        $display("FAIL n1_toggle: cycle %0d pos=%b step=%b an=%b seg=%b required %b 1 1 %b",
                 k, pos_c, step_c, an_c, seg_c, exp_pos, exp_pos ? BOT : TOP);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cw_loop();
    test_ccw_wrap();
    test_enable_dir();
    test_blank();
    test_reset_mid();
    test_tick_div1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
